// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle sequencer and the RV32I datapath.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_source;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       instr_done;
  logic       illegal;
  logic       mem_error;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_source, ir_write, iord, mem_read, mem_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, state,
           instr_done, illegal, mem_error
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_source, ir_write, iord, mem_read, mem_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, state,
           instr_done, illegal, mem_error
  );
endinterface

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I datapath (R, I-ALU, lw, sw, beq):
// FETCH/DECODE/EXEC/MEM/WB with memory-ready waits and a timeout HALT.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_R    = 3'd1,
    C_IALU = 3'd2,
    C_LW   = 3'd3,
    C_SW   = 3'd4,
    C_BEQ  = 3'd5
  } class_e;

  state_e           state_q, state_d;
  class_e           cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_error_q, mem_error_d;
  logic             waiting;
  class_e           dec_cls;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      cls_q       <= C_NOP;
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  always_comb begin
    dec_cls = C_NOP;
    case (bus.opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_IALU;
      7'b0000011: dec_cls = C_LW;
      7'b0100011: dec_cls = C_SW;
      7'b1100011: dec_cls = C_BEQ;
      default:    dec_cls = C_NOP;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    waiting = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready)                    state_d = DECODE;
        else if (cnt_q == CNT_W'(TIMEOUT))    state_d = HALT;
        else                                  waiting = 1'b1;
      end
      DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == C_NOP) ? FETCH : EXEC;
      end
      EXEC: begin
        case (cls_q)
          C_R, C_IALU: state_d = WB;
          C_LW, C_SW:  state_d = MEM;
          default:     state_d = FETCH;
        endcase
      end
      MEM: begin
        if (bus.mem_ready)                    state_d = (cls_q == C_LW) ? WB : FETCH;
        else if (cnt_q == CNT_W'(TIMEOUT))    state_d = HALT;
        else                                  waiting = 1'b1;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // Counter restarts on any transition; it saturates rather than wrapping.
    cnt_d = cnt_q;
    if (state_d != state_q)          cnt_d = '0;
    else if (waiting && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    mem_error_d = mem_error_q | ((state_d == HALT) && (state_q != HALT));
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_source  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    bus.mem_error  = mem_error_q;
    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b = 2'b10;
        if (dec_cls == C_NOP) begin
          bus.illegal    = 1'b1;
          bus.instr_done = 1'b1;
        end
      end
      EXEC: begin
        bus.alu_src_a = 2'b01;
        case (cls_q)
          C_R:         bus.alu_op = 2'b10;
          C_IALU: begin
            bus.alu_src_b = 2'b10;
            bus.alu_op    = 2'b10;
          end
          C_LW, C_SW:  bus.alu_src_b = 2'b10;
          C_BEQ: begin
            bus.alu_op     = 2'b01;
            bus.pc_source  = 1'b1;
            bus.pc_write   = bus.zero;
            bus.instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        bus.iord       = 1'b1;
        bus.mem_read   = (cls_q == C_LW);
        bus.mem_write  = (cls_q == C_SW);
        bus.instr_done = (cls_q == C_SW) && bus.mem_ready;
      end
      WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = (cls_q == C_LW);
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase

    // Reset suppresses every strobe so no partial PC/register/memory write escapes.
    if (reset) begin
      bus.pc_write   = 1'b0;
      bus.pc_source  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 2'b00;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
      bus.mem_error  = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule
